sp_ram_rr_arbiter: RTL and testbench
====================================

Name: sp_ram_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port synchronous RAM (sp_ram, 64x8 default) between two requesters, A and B.
- Each requester sees a req/gnt handshake and a read-return channel (rvalid/rdata).
- Sits directly in front of sp_ram and drives its we/addr/data; consumes its q.
- sp_ram read latency: q is valid in the cycle after the address is sampled.

Parameters:
- ADDR_WIDTH, 6: RAM address width (depth = 2**ADDR_WIDTH).
- DATA_WIDTH, 8: RAM data width.
- INIT_VALUE, 0: fill word written during the init sweep (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_req  input  1  requester A access request; held until a_gnt.
- a_we  input  1  A: 1=write, 0=read.
- a_addr  input  ADDR_WIDTH  A address.
- a_wdata  input  DATA_WIDTH  A write data.
- a_gnt  output  1  A request accepted this cycle.
- a_rvalid  output  1  A read data valid.
- a_rdata  output  DATA_WIDTH  A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for requester B.
- ram_we  output  1  to sp_ram we.
- ram_addr  output  ADDR_WIDTH  to sp_ram addr.
- ram_data  output  DATA_WIDTH  to sp_ram data.
- ram_q  input  DATA_WIDTH  from sp_ram q.
- busy  output  1  arbiter not accepting requests (init sweep).

Behaviour:
- Reset values (rst_n=0, asynchronous): a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, ram_we=0, ram_addr=0, ram_data=0, busy=0 (1 with the optional feature). Priority pointer = A. Read-tag registers are cleared.
- Grant is combinational in cycle N from the req inputs and the priority pointer:
  - Only one req high: that requester is granted.
  - Both high: the requester named by the pointer is granted.
  - Neither high, or busy=1: no grant.
- At most one gnt is high per cycle. gnt is never high while busy=1.
- In a grant cycle, ram_we/ram_addr/ram_data are driven combinationally from the granted port. When no grant: ram_we=0, ram_addr holds its last value, ram_data holds its last value.
- Pointer update, at the rising edge ending a grant cycle: pointer becomes the non-granted requester. No grant leaves the pointer unchanged. This guarantees alternation under continuous contention.
- Requester protocol:
  - req, we, addr and wdata must be stable from req rise until the gnt cycle.
  - Dropping req before gnt is legal; the request is withdrawn.
  - req high in the cycle after gnt is a new request.
- Write: RAM updated at the edge ending the gnt cycle. No rvalid is produced.
- Read granted in cycle N: the x_rvalid register is set, so x_rvalid=1 in cycle N+1 only. x_rdata = ram_q captured combinationally in N+1 and registered into x_rdata, so it holds until the next read return for that port.
- Back-to-back reads (grants in N and N+1): rvalid is high for both N+1 and N+2, with the correct data each cycle.
- Read and write to the same address in consecutive cycles by different requesters: the read returns the value stored before or after the write, strictly by grant order.
- Reset asserted mid-operation: pending rvalid is dropped, no spurious ram_we, and the pointer returns to A.

Optional Feature:
- Macro: SP_RAM_ARB_INIT_EN.
- Defined: a two-state FSM, INIT then ARB.
  - After reset release, INIT writes INIT_VALUE to addresses 0..2**ADDR_WIDTH-1, one per cycle: ram_we=1, ram_addr=counter.
  - busy=1 throughout INIT; all requests are held off with no gnt.
  - After the write to the last address, the next cycle enters ARB with busy=0, so 64 cycles at default.
  - The counter wraps to 0 without overflow artifacts.
  - Reset during INIT restarts the sweep from 0.
- Not defined: no FSM, busy tied 0, and arbitration starts in the first cycle after reset release. RAM contents are left undefined.

Test Plan:
- A-only traffic: write addr 5=0xA5, then read addr 5 -> a_gnt in each request cycle, a_rvalid one cycle after the read grant, a_rdata=0xA5, b_gnt never 1.
- Continuous contention: a_req=b_req=1 for 8 cycles after reset -> grants A,B,A,B,A,B,A,B, never both high.
- Cross-port: B writes addr 63=0x3C; A reads 63 in the next grant -> a_rdata=0x3C. b_rvalid stays 0.
- Back-to-back reads: A reads addr 0, then B reads addr 1, in consecutive grants (contents 0x11/0x22) -> a_rvalid/0x11 at N+1, b_rvalid/0x22 at N+2.
- Reset mid-read: assert rst_n=0 in the cycle after a read grant -> a_rvalid=0 immediately, outputs at reset values, first grant after release goes to A under contention.
- SP_RAM_ARB_INIT_EN with INIT_VALUE=0x5A: busy=1 for exactly 64 cycles after reset and requests during that window are ungranted; then reads of addr 0, 31 and 63 return 0x5A.

Source files
------------

// File: rtl/sp_ram_rr_arbiter_if.sv
// Bus bundle between the two requesters, the round-robin arbiter and the single-port RAM.
// Handshake: x_req is held with stable x_we/x_addr/x_wdata until a cycle in which x_gnt is high;
// that cycle is the transfer. Dropping x_req before the grant withdraws the request. x_rvalid is a
// one-cycle pulse with no backpressure; x_rdata holds the last returned word.
interface sp_ram_rr_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [DATA_WIDTH-1:0] ram_q;

  logic                  busy;
  logic                  dbg_ptr;   // 1 = B holds priority
  logic                  dbg_init;  // 1 while the init sweep runs

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  ram_q,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_we, ram_addr, ram_data,
    output busy, dbg_ptr, dbg_init
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output ram_q,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_we, ram_addr, ram_data,
    input  busy, dbg_ptr, dbg_init
  );
endinterface

// File: rtl/sp_ram_rr_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM (1-cycle read latency).
// Optional SP_RAM_ARB_INIT_EN: after reset, sweep INIT_VALUE into every address while busy is high.
module sp_ram_rr_arbiter #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned INIT_VALUE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sp_ram_rr_arbiter_if.slave   bus
);

  localparam logic [DATA_WIDTH-1:0] InitWord = DATA_WIDTH'(INIT_VALUE);

  logic                  ptr_q, ptr_d;
  logic                  a_rd_q, b_rd_q;
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  busy;
  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;

`ifdef SP_RAM_ARB_INIT_EN
  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  typedef enum logic {S_INIT, S_ARB} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (state_q == S_INIT) begin
      // Counter wraps to 0 on the last address, so it is clean for any later use.
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LastAddr) begin
        state_q <= S_ARB;
        busy_q  <= 1'b0;
      end
    end
  end

  assign busy         = busy_q;
  assign init_we      = rst_n & busy_q;
  assign init_addr    = cnt_q;
  assign bus.dbg_init = (state_q == S_INIT);
`else
  assign busy         = 1'b0;
  assign init_we      = 1'b0;
  assign init_addr    = '0;
  assign bus.dbg_init = 1'b0;
`endif

  // Grants are masked during reset so outputs sit at their reset values while rst_n is low.
  logic arb_ok, a_win, b_win;
  assign arb_ok = rst_n & ~busy;
  assign a_win  = arb_ok & bus.a_req & (~bus.b_req | ~ptr_q);
  assign b_win  = arb_ok & bus.b_req & (~bus.a_req |  ptr_q);

  logic                  ram_we_c;
  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic [DATA_WIDTH-1:0] ram_data_c;

  always_comb begin
    ram_we_c   = 1'b0;
    ram_addr_c = addr_q;
    ram_data_c = data_q;
    ptr_d      = ptr_q;
    if (a_win) begin
      ram_we_c   = bus.a_we;
      ram_addr_c = bus.a_addr;
      ram_data_c = bus.a_wdata;
      ptr_d      = 1'b1;
    end else if (b_win) begin
      ram_we_c   = bus.b_we;
      ram_addr_c = bus.b_addr;
      ram_data_c = bus.b_wdata;
      ptr_d      = 1'b0;
    end else if (init_we) begin
      ram_we_c   = 1'b1;
      ram_addr_c = init_addr;
      ram_data_c = InitWord;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= 1'b0;
      a_rd_q    <= 1'b0;
      b_rd_q    <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      ptr_q  <= ptr_d;
      a_rd_q <= a_win & ~bus.a_we;
      b_rd_q <= b_win & ~bus.b_we;
      if (a_rd_q) a_rdata_q <= bus.ram_q;
      if (b_rd_q) b_rdata_q <= bus.ram_q;
      addr_q <= ram_addr_c;
      data_q <= ram_data_c;
    end
  end

  // RAM q is forwarded in the return cycle and latched so rdata holds until the next return.
  assign bus.a_gnt    = a_win;
  assign bus.b_gnt    = b_win;
  assign bus.a_rvalid = a_rd_q;
  assign bus.b_rvalid = b_rd_q;
  assign bus.a_rdata  = a_rd_q ? bus.ram_q : a_rdata_q;
  assign bus.b_rdata  = b_rd_q ? bus.ram_q : b_rdata_q;
  assign bus.ram_we   = ram_we_c;
  assign bus.ram_addr = ram_addr_c;
  assign bus.ram_data = ram_data_c;
  assign bus.busy     = busy;
  assign bus.dbg_ptr  = ptr_q;

endmodule

// File: tb/tb_sp_ram_rr_arbiter.sv
// Bench for sp_ram_rr_arbiter: table vectors, reset/init sequences and random traffic vs a model.
module tb_sp_ram_rr_arbiter;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam logic [DW-1:0] INIT_WORD = 8'h5A;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sp_ram_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sp_ram_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(32'h5A)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Single-port synchronous RAM, q valid the cycle after the address is sampled.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_data;
    bus.ram_q <= ram_mem[bus.ram_addr];
  end

  // ---------------- scoreboard / reference model ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  bit            m_pri_b;           // requester that wins the next tie is B
  logic [DW-1:0] exp_a_q[$];
  logic [DW-1:0] exp_b_q[$];
  bit            a_due, b_due;
  logic [DW-1:0] a_hold, b_hold;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_data;
  bit            m_ga, m_gb;

  typedef struct {
    bit            a_req;
    bit            a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    bit            b_req;
    bit            b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    bit            x_ag;
    bit            x_bg;
    bit            x_arv;
    logic [DW-1:0] x_ard;
    bit            x_brv;
    logic [DW-1:0] x_brd;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input int ar, input int aw, input int aa, input int ad,
                              input int br, input int bw, input int ba, input int bd,
                              input int xag, input int xbg, input int xarv, input int xard,
                              input int xbrv, input int xbrd);
    vec_t v;
    v.a_req = (ar != 0);  v.a_we = (aw != 0);  v.a_addr = AW'(aa);  v.a_wdata = DW'(ad);
    v.b_req = (br != 0);  v.b_we = (bw != 0);  v.b_addr = AW'(ba);  v.b_wdata = DW'(bd);
    v.x_ag  = (xag != 0); v.x_bg = (xbg != 0); v.x_arv = (xarv != 0); v.x_ard = DW'(xard);
    v.x_brv = (xbrv != 0); v.x_brd = DW'(xbrd);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    bus.a_req = v.a_req; bus.a_we = v.a_we; bus.a_addr = v.a_addr; bus.a_wdata = v.a_wdata;
    bus.b_req = v.b_req; bus.b_we = v.b_we; bus.b_addr = v.b_addr; bus.b_wdata = v.b_wdata;
  endtask

  task automatic model_reset();
    m_pri_b = 1'b0;
    exp_a_q.delete();
    exp_b_q.delete();
    a_due = 1'b0;  b_due = 1'b0;
    a_hold = '0;   b_hold = '0;
    m_last_addr = '0;
    m_last_data = '0;
    m_ga = 1'b0;   m_gb = 1'b0;
  endtask

  // Called #1 after a rising edge; checks at the falling edge, updates the model at the next edge.
  task automatic cycle(input vec_t v, input bit use_exp);
    bit ga, gb;
    drive(v);
    @(negedge clk);
    ga = v.a_req && (!v.b_req || !m_pri_b);
    gb = v.b_req && (!v.a_req ||  m_pri_b);
    chk("a_gnt", bus.a_gnt, ga);
    chk("b_gnt", bus.b_gnt, gb);
    chk("busy", bus.busy, 0);
    chk("a_rvalid", bus.a_rvalid, a_due);
    chk("b_rvalid", bus.b_rvalid, b_due);
    if (a_due && exp_a_q.size() > 0) a_hold = exp_a_q.pop_front();
    if (b_due && exp_b_q.size() > 0) b_hold = exp_b_q.pop_front();
    chk("a_rdata", bus.a_rdata, a_hold);
    chk("b_rdata", bus.b_rdata, b_hold);
    if (ga) begin
      m_last_addr = v.a_addr; m_last_data = v.a_wdata;
    end else if (gb) begin
      m_last_addr = v.b_addr; m_last_data = v.b_wdata;
    end
    chk("ram_we", bus.ram_we, (ga && v.a_we) || (gb && v.b_we));
    chk("ram_addr", bus.ram_addr, m_last_addr);
    chk("ram_data", bus.ram_data, m_last_data);
    if (use_exp) begin
      chk("tbl_a_gnt", bus.a_gnt, v.x_ag);
      chk("tbl_b_gnt", bus.b_gnt, v.x_bg);
      chk("tbl_a_rvalid", bus.a_rvalid, v.x_arv);
      chk("tbl_a_rdata", bus.a_rdata, v.x_ard);
      chk("tbl_b_rvalid", bus.b_rvalid, v.x_brv);
      chk("tbl_b_rdata", bus.b_rdata, v.x_brd);
    end
    @(posedge clk);
    a_due = ga && !v.a_we;
    b_due = gb && !v.b_we;
    if (ga) begin
      if (v.a_we) begin m_mem[v.a_addr] = v.a_wdata; m_known[v.a_addr] = 1'b1; end
      else exp_a_q.push_back(m_mem[v.a_addr]);
      m_pri_b = 1'b1;
    end else if (gb) begin
      if (v.b_we) begin m_mem[v.b_addr] = v.b_wdata; m_known[v.b_addr] = 1'b1; end
      else exp_b_q.push_back(m_mem[v.b_addr]);
      m_pri_b = 1'b0;
    end
    m_ga = ga;
    m_gb = gb;
    #1;
  endtask

  task automatic init_phase();
`ifdef SP_RAM_ARB_INIT_EN
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.b_req = 1'b1; bus.b_we = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      chk("init_busy", bus.busy, 1);
      chk("init_a_gnt", bus.a_gnt, 0);
      chk("init_b_gnt", bus.b_gnt, 0);
      chk("init_ram_we", bus.ram_we, 1);
      chk("init_ram_addr", bus.ram_addr, k);
      chk("init_ram_data", bus.ram_data, INIT_WORD);
      @(posedge clk);
      #1;
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      m_mem[k]   = INIT_WORD;
      m_known[k] = 1'b1;
    end
    m_last_addr = AW'(DEPTH - 1);
    m_last_data = INIT_WORD;
`endif
  endtask

  task automatic do_reset();
    drive(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0));
    rst_n = 1'b0;
    #1;
    chk("rst_a_gnt", bus.a_gnt, 0);
    chk("rst_b_gnt", bus.b_gnt, 0);
    chk("rst_a_rvalid", bus.a_rvalid, 0);
    chk("rst_b_rvalid", bus.b_rvalid, 0);
    chk("rst_a_rdata", bus.a_rdata, 0);
    chk("rst_b_rdata", bus.b_rdata, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_data", bus.ram_data, 0);
`ifdef SP_RAM_ARB_INIT_EN
    chk("rst_busy", bus.busy, 1);
`else
    chk("rst_busy", bus.busy, 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    init_phase();
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    vec_t v;
    bit   pa, pb;

    for (int k = 0; k < DEPTH; k++) m_known[k] = 1'b0;
    model_reset();
    do_reset();

    // Directed vectors; priority starts at A.
    tbl[0]  = mk(0,0, 0,   0,    0,0, 0,   0,    0,0,0,8'h00,0,8'h00);
    tbl[1]  = mk(1,1, 5,8'hA5,   0,0, 0,   0,    1,0,0,8'h00,0,8'h00);
    tbl[2]  = mk(1,0, 5,   0,    0,0, 0,   0,    1,0,0,8'h00,0,8'h00);
    tbl[3]  = mk(0,0, 0,   0,    0,0, 0,   0,    0,0,1,8'hA5,0,8'h00);
    tbl[4]  = mk(0,0, 0,   0,    1,1,63,8'h3C,   0,1,0,8'hA5,0,8'h00);
    tbl[5]  = mk(1,0,63,   0,    0,0, 0,   0,    1,0,0,8'hA5,0,8'h00);
    tbl[6]  = mk(1,1, 0,8'h11,   0,0, 0,   0,    1,0,1,8'h3C,0,8'h00);
    tbl[7]  = mk(0,0, 0,   0,    1,1, 1,8'h22,   0,1,0,8'h3C,0,8'h00);
    tbl[8]  = mk(1,0, 0,   0,    1,0, 1,   0,    1,0,0,8'h3C,0,8'h00);
    tbl[9]  = mk(0,0, 0,   0,    1,0, 1,   0,    0,1,1,8'h11,0,8'h00);
    tbl[10] = mk(0,0, 0,   0,    0,0, 0,   0,    0,0,0,8'h11,1,8'h22);
    for (int i = 0; i < 8; i++)
      tbl[11+i] = mk(1,1,10,i, 1,1,11,8'h80+i, (i%2==0),(i%2==1),0,8'h11,0,8'h22);
    for (int i = 0; i < 19; i++) cycle(tbl[i], 1'b1);

    // Reset in the cycle after a read grant.
    cycle(mk(1,0,5,0, 0,0,0,0, 0,0,0,0,0,0), 1'b0);
    chk("pre_rst_a_rvalid", bus.a_rvalid, 1);
    drive(mk(1,0,5,0, 1,0,63,0, 0,0,0,0,0,0));
    rst_n = 1'b0;
    #1;
    chk("midrst_a_rvalid", bus.a_rvalid, 0);
    chk("midrst_a_gnt", bus.a_gnt, 0);
    chk("midrst_b_gnt", bus.b_gnt, 0);
    chk("midrst_ram_we", bus.ram_we, 0);
    do_reset();
    v = mk(1,0,5,0, 1,0,63,0, 1,0,0,8'h00,0,8'h00);
    cycle(v, 1'b1);
    v = mk(0,0,0,0, 1,0,63,0, 0,1,1,8'hA5,0,8'h00);
    cycle(v, 1'b1);
    cycle(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0), 1'b0);

`ifdef SP_RAM_ARB_INIT_EN
    cycle(mk(1,0, 0,0, 0,0,0,0, 0,0,0,0,0,0), 1'b0);
    cycle(mk(1,0,31,0, 0,0,0,0, 0,0,0,0,0,0), 1'b0);
    chk("init_rd0", bus.a_rdata, INIT_WORD);
    cycle(mk(1,0,63,0, 0,0,0,0, 0,0,0,0,0,0), 1'b0);
    chk("init_rd31", bus.a_rdata, INIT_WORD);
    cycle(mk(0,0, 0,0, 0,0,0,0, 0,0,0,0,0,0), 1'b0);
    chk("init_rd63", bus.a_rdata, INIT_WORD);
`endif

    // Random traffic: requests stay stable until granted, occasionally withdrawn.
    v  = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0);
    pa = 1'b0;
    pb = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (m_ga) pa = 1'b0;
      if (m_gb) pb = 1'b0;
      if (!pa) begin
        if ($urandom_range(0, 3) != 0) begin
          pa = 1'b1;
          v.a_we    = ($urandom_range(0, 1) == 1);
          v.a_addr  = AW'($urandom_range(0, DEPTH - 1));
          v.a_wdata = DW'($urandom_range(0, 255));
          if (!v.a_we && !m_known[v.a_addr]) v.a_we = 1'b1;
        end
      end else if ($urandom_range(0, 19) == 0) pa = 1'b0;
      if (!pb) begin
        if ($urandom_range(0, 3) != 0) begin
          pb = 1'b1;
          v.b_we    = ($urandom_range(0, 1) == 1);
          v.b_addr  = AW'($urandom_range(0, DEPTH - 1));
          v.b_wdata = DW'($urandom_range(0, 255));
          if (!v.b_we && !m_known[v.b_addr]) v.b_we = 1'b1;
        end
      end else if ($urandom_range(0, 19) == 0) pb = 1'b0;
      v.a_req = pa;
      v.b_req = pb;
      cycle(v, 1'b0);
    end
    cycle(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0), 1'b0);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    n_err++;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
